// File: rtl/dht11_disp_pkg.sv
// Shared display constants for the DHT11 7-segment scanner.
// Segment codes are active-low, bit order g..a.
package dht11_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
        7'h12, 7'h02, 7'h78, 7'h00, 7'h10
    };

    // Scan order, rightmost digit first
    localparam logic [1:0] DIG_HUM_ONE = 2'd0;
    localparam logic [1:0] DIG_HUM_TEN = 2'd1;
    localparam logic [1:0] DIG_TMP_ONE = 2'd2;
    localparam logic [1:0] DIG_TMP_TEN = 2'd3;

    typedef struct packed {
        logic [3:0] tmp_ten;
        logic [3:0] tmp_one;
        logic [3:0] hum_ten;
        logic [3:0] hum_one;
    } reading_t;

    // Tens positions get leading-zero blanking
    function automatic logic is_ten_digit(input logic [1:0] idx);
        return idx[0];
    endfunction

endpackage

// File: rtl/dht11_seg_scan_if.sv
// Sensor-reading input and display output bundle for dht11_seg_scan.
// data_rdy is a one-cycle strobe with no back-pressure: the four BCD digits are valid only in that cycle.
interface dht11_seg_scan_if;

    logic       data_rdy;
    logic [3:0] temperature_ten;
    logic [3:0] temperature_one;
    logic [3:0] humidity_ten;
    logic [3:0] humidity_one;
    logic [7:0] seg;
    logic [3:0] dig;
    logic       stale;

    modport master (
        output data_rdy, temperature_ten, temperature_one, humidity_ten, humidity_one,
        input  seg, dig, stale
    );

    modport slave (
        input  data_rdy, temperature_ten, temperature_one, humidity_ten, humidity_one,
        output seg, dig, stale
    );

endinterface

// File: rtl/dht11_seg_scan_seg7_decode.sv
// BCD to active-low 7-segment glyph; dash overrides blank, and non-decimal codes show a dash.
module seg7_decode
    import dht11_disp_pkg::*;
(
    input  logic [3:0] bcd,
    input  logic       blank,
    input  logic       dash,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_DASH;
        if (dash) begin
            seg = SEG_DASH;
        end else if (blank && bcd == 4'd0) begin
            seg = SEG_BLANK;
        end else begin
            case (bcd)
                4'd0:    seg = SEG_DIGIT[0];
                4'd1:    seg = SEG_DIGIT[1];
                4'd2:    seg = SEG_DIGIT[2];
                4'd3:    seg = SEG_DIGIT[3];
                4'd4:    seg = SEG_DIGIT[4];
                4'd5:    seg = SEG_DIGIT[5];
                4'd6:    seg = SEG_DIGIT[6];
                4'd7:    seg = SEG_DIGIT[7];
                4'd8:    seg = SEG_DIGIT[8];
                4'd9:    seg = SEG_DIGIT[9];
                default: seg = SEG_DASH;
            endcase
        end
    end

endmodule

// File: rtl/dht11_seg_scan.sv
// Multiplexed 4-digit common-anode display for DHT11 readings: tear-free frame latching,
// leading-zero blanking, and a blinking stale indication when readings stop.
module dht11_seg_scan
    import dht11_disp_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int STALE_MS = 5000,
    parameter int BLINK_MS = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    dht11_seg_scan_if.slave bus
);

    localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int TW = $clog2(STALE_MS + 1);
    localparam int BW = (BLINK_MS > 1) ? $clog2(BLINK_MS) : 1;

    logic [SW-1:0] slot_cnt;
    logic          tick;
    logic [1:0]    idx;
    logic          frame;

    reading_t      live;
    reading_t      pend;
    reading_t      disp;
    logic          pending;
    logic          have_data;
    logic          disp_valid;

    logic [TW-1:0] stale_cnt;
    logic          stale_hit;
    logic [BW-1:0] blink_cnt;
    logic          blink_off;

    logic [3:0]    cur_bcd;
    logic          cur_dash;
    logic          cur_blank;
    logic [6:0]    glyph;
    logic [7:0]    seg_q;
    logic [3:0]    dig_q;

    assign live  = {bus.temperature_ten, bus.temperature_one, bus.humidity_ten, bus.humidity_one};
    assign tick  = (slot_cnt == SW'(SCAN_DIV - 1));
    assign frame = tick && (idx == DIG_TMP_TEN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_cnt <= '0;
            idx      <= '0;
        end else begin
            slot_cnt <= tick ? '0 : slot_cnt + 1'b1;
            if (tick) idx <= idx + 2'd1;
        end
    end

    // Readings land in pend first and only reach disp between frames,
    // so a scan never mixes digits from two readings.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            disp       <= '0;
            pending    <= 1'b0;
            have_data  <= 1'b0;
            disp_valid <= 1'b0;
        end else if (bus.data_rdy) begin
            have_data <= 1'b1;
            if (frame) begin
                disp       <= live;
                disp_valid <= 1'b1;
                pending    <= 1'b0;
            end else begin
                pend    <= live;
                pending <= 1'b1;
            end
        end else if (frame && pending) begin
            disp       <= pend;
            disp_valid <= 1'b1;
            pending    <= 1'b0;
        end
    end

    assign stale_hit = (stale_cnt == TW'(STALE_MS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stale_cnt <= '0;
        end else if (bus.data_rdy) begin
            stale_cnt <= '0;
        end else if (have_data && tick && !stale_hit) begin
            stale_cnt <= stale_cnt + 1'b1;
        end
    end

    // A fresh reading forces the phase back on, even on a blink-toggle tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (!stale_hit || bus.data_rdy) begin
            blink_cnt <= '0;
            blink_off <= 1'b0;
        end else if (tick) begin
            if (blink_cnt == BW'(BLINK_MS - 1)) begin
                blink_cnt <= '0;
                blink_off <= ~blink_off;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        cur_bcd = disp.hum_one;
        case (idx)
            DIG_HUM_ONE: cur_bcd = disp.hum_one;
            DIG_HUM_TEN: cur_bcd = disp.hum_ten;
            DIG_TMP_ONE: cur_bcd = disp.tmp_one;
            DIG_TMP_TEN: cur_bcd = disp.tmp_ten;
            default:     cur_bcd = disp.hum_one;
        endcase
    end

    assign cur_dash  = !disp_valid || (cur_bcd > 4'd9);
    assign cur_blank = is_ten_digit(idx);

    seg7_decode u_decode (
        .bcd   (cur_bcd),
        .blank (cur_blank),
        .dash  (cur_dash),
        .seg   (glyph)
    );

    // One-cycle registered view of the current index; dark phase keeps scanning underneath.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= 8'hFF;
            dig_q <= 4'b1111;
        end else if (blink_off) begin
            seg_q <= 8'hFF;
            dig_q <= 4'b1111;
        end else begin
            seg_q <= {(idx != DIG_TMP_ONE), glyph};
            dig_q <= ~(4'b0001 << idx);
        end
    end

    assign bus.seg   = seg_q;
    assign bus.dig   = dig_q;
    assign bus.stale = stale_hit && !bus.data_rdy;

endmodule

// File: tb/tb_dht11_seg_scan.sv
// Self-checking bench for dht11_seg_scan: cycle-level reference model plus directed pins.
module tb_dht11_seg_scan;

  localparam int SCAN_DIV = 4;
  localparam int STALE_MS = 20;
  localparam int BLINK_MS = 4;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  dht11_seg_scan_if bus ();

  dht11_seg_scan #(
    .SCAN_DIV (SCAN_DIV),
    .STALE_MS (STALE_MS),
    .BLINK_MS (BLINK_MS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state: clock edges since reset, slots since the last reading
  int          m_n;
  int          m_ticks;
  bit          m_have;
  bit          m_fresh;
  bit          m_shown_valid;
  logic [15:0] m_latest;
  logic [15:0] m_shown;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_dig;

  function automatic logic [6:0] glyph(input logic [3:0] v, input bit valid, input bit ten);
    if (!valid || v > 4'd9) return 7'h3F;
    if (ten && v == 4'd0) return 7'h7F;
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      default: return 7'h10;
    endcase
  endfunction

  task automatic model_reset();
    m_n = 0;
    m_ticks = 0;
    m_have = 0;
    m_fresh = 0;
    m_shown_valid = 0;
    m_latest = '0;
    m_shown = '0;
    exp_seg = 8'hFF;
    exp_dig = 4'b1111;
  endtask

  task automatic model_step();
    int idx_e;
    bit dark;
    bit is_tick;
    idx_e = (m_n / SCAN_DIV) % 4;
    is_tick = (m_n % SCAN_DIV) == SCAN_DIV - 1;
    dark = m_have && (m_ticks >= STALE_MS) && ((((m_ticks - STALE_MS) / BLINK_MS) % 2) == 1);
    if (dark) begin
      exp_seg = 8'hFF;
      exp_dig = 4'b1111;
    end else begin
      exp_dig = ~(4'b0001 << idx_e);
      exp_seg = {(idx_e != 2), glyph(m_shown[idx_e*4 +: 4], m_shown_valid, (idx_e % 2) == 1)};
    end
    if (bus.data_rdy) begin
      m_latest = {bus.temperature_ten, bus.temperature_one, bus.humidity_ten, bus.humidity_one};
      m_have = 1;
      m_fresh = 1;
      m_ticks = 0;
    end else if (is_tick && m_have) begin
      m_ticks = m_ticks + 1;
    end
    if (is_tick && idx_e == 3 && m_fresh) begin
      m_shown = m_latest;
      m_shown_valid = 1;
      m_fresh = 0;
    end
    m_n = m_n + 1;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total = total + 1;
    if (got !== want) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        check("reset seg", bus.seg, 8'hFF);
        check("reset dig", bus.dig, 4'b1111);
        check("reset stale", bus.stale, 1'b0);
      end else begin
        check("model seg", bus.seg, exp_seg);
        check("model dig", bus.dig, exp_dig);
        check("model stale", bus.stale,
              m_have && (m_ticks >= STALE_MS) && (bus.data_rdy == 1'b0));
      end
    end
  end

  task automatic set_inputs(input logic [3:0] tt, input logic [3:0] to_,
                            input logic [3:0] ht, input logic [3:0] ho);
    bus.temperature_ten = tt;
    bus.temperature_one = to_;
    bus.humidity_ten    = ht;
    bus.humidity_one    = ho;
  endtask

  // Strobe data_rdy so it is captured on the first edge whose edge count n satisfies n % md == res
  task automatic drive_at(input int md, input int res, input logic [3:0] tt, input logic [3:0] to_,
                          input logic [3:0] ht, input logic [3:0] ho);
    int guard;
    guard = 0;
    @(posedge clk);
    #1;
    while ((m_n % md) != res && guard < 64) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 64) check("drive_at alignment timeout", guard, 0);
    set_inputs(tt, to_, ht, ho);
    bus.data_rdy = 1'b1;
    @(posedge clk);
    #1;
    bus.data_rdy = 1'b0;
  endtask

  task automatic pin_digit(input logic [3:0] d, input logic [7:0] want, input string name);
    int guard;
    guard = 0;
    @(posedge clk);
    #2;
    while (bus.dig !== d && guard < 64) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (guard >= 64) check({name, " dig timeout"}, bus.dig, d);
    else check(name, bus.seg, want);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    bus.data_rdy = 1'b0;
    set_inputs(4'd0, 4'd0, 4'd0, 4'd0);
    repeat (3) @(posedge clk);
    #2;
    check("pin reset seg", bus.seg, 8'hFF);
    check("pin reset dig", bus.dig, 4'b1111);
    check("pin reset stale", bus.stale, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // No data yet: dashes everywhere, dp only on the temperature-ones digit
    repeat (40) @(posedge clk);
    pin_digit(4'b1011, 8'h3F, "idle dash with dp");
    pin_digit(4'b1110, 8'hBF, "idle dash no dp");

    // Mid-frame reading: old dashes must persist until the next frame
    drive_at(1, 0, 4'd2, 4'd5, 4'd0, 4'd7);
    #1;
    check("old dash persists", bus.seg[6:0], 7'h3F);
    repeat (20) @(posedge clk);
    pin_digit(4'b1011, 8'h12, "tmp one 5 with dp");
    pin_digit(4'b0111, 8'hA4, "tmp ten 2");
    pin_digit(4'b1101, 8'hFF, "hum ten blank");
    pin_digit(4'b1110, 8'hF8, "hum one 7");

    // Reading on the frame-boundary tick shows in the very next frame
    drive_at(FRAME, FRAME - 1, 4'd3, 4'd1, 4'd0, 4'd7);
    pin_digit(4'b1011, 8'h79, "boundary tmp one 1");
    pin_digit(4'b0111, 8'hB0, "boundary tmp ten 3");

    // Stale after 20 slots, then blink, then recovery on a new reading
    drive_at(SCAN_DIV, SCAN_DIV - 1, 4'd3, 4'd1, 4'd0, 4'd7);
    repeat (79) @(posedge clk);
    #2;
    check("stale low before 20th tick", bus.stale, 1'b0);
    @(posedge clk);
    #2;
    check("stale high after 20th tick", bus.stale, 1'b1);
    repeat (20) @(posedge clk);
    #2;
    check("blink dark seg", bus.seg, 8'hFF);
    check("blink dark dig", bus.dig, 4'b1111);
    repeat (16) @(posedge clk);
    #2;
    check("blink lit dig", (bus.dig !== 4'b1111), 1'b1);
    @(posedge clk);
    #1;
    bus.data_rdy = 1'b1;
    #1;
    check("stale drops with data_rdy", bus.stale, 1'b0);
    @(posedge clk);
    #1;
    bus.data_rdy = 1'b0;
    repeat (8) @(posedge clk);

    // Non-decimal humidity ones shows a dash, neighbours untouched
    drive_at(1, 0, 4'd3, 4'd1, 4'd0, 4'hC);
    repeat (40) @(posedge clk);
    pin_digit(4'b1110, 8'hBF, "bad bcd dash");
    pin_digit(4'b1011, 8'h79, "tmp one unaffected");
    pin_digit(4'b0111, 8'hB0, "tmp ten unaffected");

    // Asynchronous reset while stale, mid-slot
    repeat (85) @(posedge clk);
    #2;
    check("stale before reset", bus.stale, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("async reset seg", bus.seg, 8'hFF);
    check("async reset dig", bus.dig, 4'b1111);
    check("async reset stale", bus.stale, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #2;
    check("resume idx0 dig", bus.dig, 4'b1110);
    check("resume idx0 seg", bus.seg, 8'hBF);
    repeat (20) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
